// File: rtl/seq_match_ctrl_if.sv
// Handshake/bus bundle for seq_match_ctrl: config write, arm/abort, serial sample and event ports.
// The master side drives the controller's inputs; the slave modport is the controller itself.
interface seq_match_ctrl_if #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
);
   // valid/ready: a transfer happens on a posedge where both are 1; the source holds
   // its payload stable while valid=1 and ready=0.
   logic             cfg_valid;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern;
   logic [CNT_W-1:0] cfg_thresh;
   logic [WIN_W-1:0] cfg_window;
   logic             start;
   logic             abort;
   logic             x_valid;
   logic             x_in;
   logic             evt_valid;
   logic             evt_ready;
   logic [CNT_W-1:0] evt_count;
   logic             evt_timeout;
   logic             busy;
   logic [1:0]       state_dbg;

   modport master (
      output cfg_valid, cfg_pattern, cfg_thresh, cfg_window, start, abort,
             x_valid, x_in, evt_ready,
      input  cfg_ready, evt_valid, evt_count, evt_timeout, busy, state_dbg
   );

   modport slave (
      input  cfg_valid, cfg_pattern, cfg_thresh, cfg_window, start, abort,
             x_valid, x_in, evt_ready,
      output cfg_ready, evt_valid, evt_count, evt_timeout, busy, state_dbg
   );
endinterface

// File: rtl/seq_match_ctrl.sv
// Serial pattern detector: counts pattern hits over a sample window and reports via an event port.
// Build option SEQ_OVERLAP_EN: keep history after a match so overlapping hits count.
module seq_match_ctrl #(
   parameter int               PAT_W       = 3,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 3'b101,
   parameter int               CNT_W       = 8,
   parameter int               WIN_W       = 16
) (
   input logic              clk,
   input logic              reset,
   seq_match_ctrl_if.slave  bus
);
   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic [CNT_W-1:0]   thresh_q, thresh_d;
   logic [WIN_W-1:0]   window_q, window_d;
   logic [PAT_W-1:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]   hits_q, hits_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0]   evt_count_q, evt_count_d;
   logic               evt_to_q, evt_to_d;

   logic [PAT_W-1:0]   hist_shift;
   logic [FILL_W-1:0]  fill_inc;
   logic [WIN_W-1:0]   win_inc;
   logic [CNT_W-1:0]   hits_inc;
   logic               match;

   assign hist_shift = {hist_q[PAT_W-2:0], bus.x_in};
   assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
   assign win_inc    = win_cnt_q + 1'b1;
   assign hits_inc   = (&hits_q) ? hits_q : hits_q + 1'b1;
   assign match      = (fill_inc == FILL_FULL) && (hist_shift == pattern_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pattern_q   <= PAT_DEFAULT;
         thresh_q    <= CNT_W'(1);
         window_q    <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         hits_q      <= '0;
         win_cnt_q   <= '0;
         evt_count_q <= '0;
         evt_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         thresh_q    <= thresh_d;
         window_q    <= window_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         hits_q      <= hits_d;
         win_cnt_q   <= win_cnt_d;
         evt_count_q <= evt_count_d;
         evt_to_q    <= evt_to_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      thresh_d    = thresh_q;
      window_d    = window_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      hits_d      = hits_q;
      win_cnt_d   = win_cnt_q;
      evt_count_d = evt_count_q;
      evt_to_d    = evt_to_q;

      case (state_q)
         IDLE: begin
            // Threshold 0 is stored as 1 so the hit compare below never needs a special case.
            if (bus.cfg_valid) begin
               pattern_d = bus.cfg_pattern;
               thresh_d  = (bus.cfg_thresh == '0) ? CNT_W'(1) : bus.cfg_thresh;
               window_d  = bus.cfg_window;
            end
            if (bus.start) begin
               state_d   = ARMED;
               hist_d    = '0;
               fill_d    = '0;
               hits_d    = '0;
               win_cnt_d = '0;
            end
         end

         ARMED: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.x_valid) begin
               hist_d    = hist_shift;
               fill_d    = fill_inc;
               win_cnt_d = win_inc;
               if (match) begin
                  hits_d = hits_inc;
`ifndef SEQ_OVERLAP_EN
                  hist_d = '0;
                  fill_d = '0;
`endif
               end
               // Threshold is checked first so a hit on the expiring sample reports as a hit.
               if (hits_d == thresh_q) begin
                  state_d     = REPORT;
                  evt_count_d = hits_d;
                  evt_to_d    = 1'b0;
               end else if ((window_q != '0) && (win_inc == window_q)) begin
                  state_d     = REPORT;
                  evt_count_d = hits_d;
                  evt_to_d    = 1'b1;
               end
            end
         end

         REPORT: begin
            if (bus.evt_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.cfg_ready   = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.evt_valid   = (state_q == REPORT);
   assign bus.evt_count   = evt_count_q;
   assign bus.evt_timeout = evt_to_q;
   assign bus.state_dbg   = state_q;
endmodule
